// File: rtl/mem_burst_master.sv
// Burst initiator for a single-port memory with a 1-cycle read latency.
// Reads return through a 4-entry FIFO; issue is credit-gated so it cannot overflow.
module mem_burst_master #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_last,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  busy
);

  localparam int FD = 4;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] rem;
  logic [ADDR_WIDTH-1:0] iss_addr;
  logic                  iss_last;
  logic                  issue;
  logic                  cmd_hs;
  logic                  wr_hs;
  logic                  credit;

  logic                  v1, v2;
  logic                  l1, l2;

  logic [WIDTH-1:0]      fdata [FD];
  logic                  flast [FD];
  logic [1:0]            wp, rp;
  logic [2:0]            fcnt;
  logic [2:0]            occ;
  logic                  push, pop;

  function automatic logic [ADDR_WIDTH-1:0] inc(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (a == ADDR_WIDTH'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  // FIFO occupancy plus beats still in the return pipe
  assign occ    = fcnt + {2'b00, v1} + {2'b00, v2};
  assign credit = occ < 3'd4;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          if (cmd_write)
            state_nx = WR;
          else if (issue && cmd_len == '0)
            state_nx = IDLE;
          else
            state_nx = RD;
        end
      end
      WR: if (wr_hs && rem == '0) state_nx = IDLE;
      RD: if (issue && rem == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = rst && (state == IDLE);
    wr_ready  = (state == WR);
    cmd_hs    = cmd_valid && cmd_ready;
    wr_hs     = wr_valid && wr_ready;
    issue     = 1'b0;
    iss_addr  = cnt;
    iss_last  = (rem == '0);
    unique case (1'b1)
      state == IDLE: begin
        iss_addr = cmd_addr;
        iss_last = (cmd_len == '0);
        issue    = cmd_hs && !cmd_write && credit;
      end
      state == RD: issue = credit;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      rem       <= '0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
    end else begin
      mem_wen <= wr_hs;
      if (cmd_hs) begin
        if (issue) begin
          cnt <= inc(cmd_addr);
          rem <= cmd_len - 1'b1;
        end else begin
          cnt <= cmd_addr;
          rem <= cmd_len;
        end
      end else if (wr_hs || issue) begin
        cnt <= inc(cnt);
        rem <= rem - 1'b1;
      end
      if (issue) begin
        mem_addr <= iss_addr;
      end else if (wr_hs) begin
        mem_addr  <= cnt;
        mem_wdata <= wr_data;
      end
      v1 <= issue;
      l1 <= iss_last;
      v2 <= v1;
      l2 <= l1;
    end
  end

  assign push = v2;
  assign pop  = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      fcnt <= fcnt + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fdata[wp] <= mem_rdata;
      flast[wp] <= l2;
    end
  end

  assign rd_valid = (fcnt != '0);
  assign rd_data  = rd_valid ? fdata[rp] : '0;
  assign rd_last  = rd_valid && flast[rp];
  assign busy     = (state != IDLE) || v1 || v2 || rd_valid;

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: behavioural memory, shadow memory model
// and expected read-beat queue; directed steps then random bursts.
module tb_mem_burst_master;

  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_write = 1'b0;
  logic [A-1:0] cmd_addr = '0;
  logic [A-1:0] cmd_len = '0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [W-1:0] wr_data = '0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [W-1:0] rd_data;
  logic         rd_last;
  logic         mem_wen;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic [W-1:0] mem_rdata = '0;
  logic         busy;

  mem_burst_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(A)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory: write on wen, registered read of the presented address
  logic [W-1:0] mem [D] = '{default: '0};
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  logic [W-1:0] ref_mem [D] = '{default: '0};
  logic [W-1:0] exp_d [$];
  logic         exp_l [$];
  logic [W-1:0] wq [$];
  logic         pat_q [$];
  logic [A-1:0] wseen [$];
  int           wr_ptr = 0;
  int           wprob = 100;
  int           n_checks = 0;
  int           n_pass = 0;
  int           n_fail = 0;
  int           n_rd = 0;
  logic [W-1:0] last_rd = '0;
  logic         cmd_acc = 1'b0;
  logic         wr_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic         hs_c, hs_w, hs_r;
    logic [A-1:0] ea;
    logic [W-1:0] ed;
    hs_c = cmd_valid && cmd_ready;
    hs_w = rst && wr_valid && wr_ready;
    hs_r = rst && rd_valid && rd_ready;
    ea = '0;
    ed = '0;
    if (hs_r) begin
      chk("rd_expected", 32'(exp_d.size() != 0), 1);
      if (exp_d.size() != 0) begin
        chk("rd_data", rd_data, exp_d.pop_front());
        chk("rd_last", rd_last, exp_l.pop_front());
      end
      last_rd = rd_data;
      n_rd++;
    end
    if (hs_w) begin
      ea = A'(wr_ptr);
      ed = wr_data;
      ref_mem[wr_ptr] = wr_data;
      wr_ptr = (wr_ptr + 1) % D;
    end
    if (hs_c) begin
      if (cmd_write) wr_ptr = cmd_addr;
      else
        for (int i = 0; i <= int'(cmd_len); i++) begin
          exp_d.push_back(ref_mem[(int'(cmd_addr) + i) % D]);
          exp_l.push_back(i == int'(cmd_len));
        end
    end
    cmd_acc = hs_c;
    wr_acc  = hs_w;
    @(posedge clk);
    #1;
    chk("mem_wen", mem_wen, hs_w);
    if (hs_w) begin
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
    end
    if (mem_wen) wseen.push_back(mem_addr);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b0;
    cmd_valid = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_busy", busy, 0);
    exp_d.delete();
    exp_l.delete();
    rst = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
  endtask

  task automatic do_cmd(input logic w, input int addr, input int len);
    int k;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = A'(addr);
    cmd_len   = A'(len);
    k = 0;
    do begin
      tick();
      k++;
    end while (!cmd_acc && k < 50);
    chk("cmd_accept", cmd_acc, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input int addr, input int len);
    int sent, g;
    do_cmd(1'b1, addr, len);
    sent = 0;
    g = 0;
    while (sent <= len && g < 300) begin
      if (pat_q.size() != 0) wr_valid = pat_q.pop_front();
      else wr_valid = ($urandom_range(99) < wprob);
      wr_data = wq[sent];
      tick();
      if (wr_acc) sent++;
      g++;
    end
    wr_valid = 1'b0;
    chk("write_beats", sent, len + 1);
  endtask

  task automatic drain(input int rprob);
    int g;
    g = 0;
    while ((busy || exp_d.size() != 0) && g < 400) begin
      rd_ready = ($urandom_range(99) < rprob);
      tick();
      g++;
    end
    rd_ready = 1'b1;
    chk("drain_queue", exp_d.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    int n0;
    rst = 1'b0;
    apply_reset(3);

    // write 11,22,33,44 from 6, wrapping past the top
    wprob = 100;
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    wseen.delete();
    do_write(6, 3);
    tick();
    chk("wr_wseen_n", wseen.size(), 4);
    if (wseen.size() == 4) begin
      chk("wr_addr0", wseen[0], 6);
      chk("wr_addr1", wseen[1], 7);
      chk("wr_addr2", wseen[2], 0);
      chk("wr_addr3", wseen[3], 1);
    end

    // read back with latency and back-to-back checks
    rd_ready = 1'b1;
    n0 = n_rd;
    do_cmd(1'b0, 6, 3);
    chk("rd_lat_e0", rd_valid, 0);
    tick();
    chk("rd_lat_e1", rd_valid, 0);
    tick();
    chk("rd_lat_e2", rd_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_b2b", rd_valid, 1);
    end
    drain(100);
    chk("rd_beats4", n_rd - n0, 4);
    chk("rd_last_data", last_rd, 8'h44);

    // credit stall: only 4 beats issued while consumer is stalled
    rd_ready = 1'b0;
    n0 = n_rd;
    do_cmd(1'b0, 0, 7);
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i >= 4) chk("stall_addr", mem_addr, 3);
    end
    chk("stall_valid", rd_valid, 1);
    chk("stall_busy", busy, 1);
    drain(100);
    chk("stall_beats8", n_rd - n0, 8);

    // gapped write beats
    wq = '{8'h5a, 8'h6b, 8'h7c, 8'h8d};
    pat_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_write(3, 3);
    drain(100);

    // write then immediate read of the same word
    wprob = 100;
    wq = '{8'ha5};
    do_write(2, 0);
    do_cmd(1'b0, 2, 0);
    drain(100);
    chk("wr_then_rd", last_rd, 8'ha5);

    // reset in the middle of an 8-beat read
    rd_ready = 1'b1;
    do_cmd(1'b0, 0, 7);
    tick();
    tick();
    chk("mid_rd_busy", busy, 1);
    apply_reset(1);

    // reset in the middle of a write burst, held 3 cycles
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 3'd4;
    cmd_len   = 3'd7;
    tick();
    cmd_valid = 1'b0;
    wr_valid  = 1'b1;
    wr_data   = 8'hc3;
    tick();
    tick();
    apply_reset(3);

    // random bursts
    for (int it = 0; it < 40; it++) begin
      int a, l;
      a = $urandom_range(D - 1);
      l = $urandom_range(D - 1);
      if ($urandom_range(1) == 1) begin
        wq.delete();
        for (int i = 0; i <= l; i++) wq.push_back(W'($urandom));
        wprob = $urandom_range(100, 30);
        do_write(a, l);
      end else begin
        rd_ready = ($urandom_range(1) == 1);
        do_cmd(1'b0, a, l);
        drain($urandom_range(100, 20));
      end
    end
    drain(100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
